// File: rtl/uart_cmd_wrapper.sv
// Knight-side RemoteComm endpoint: UART RX assembles a 16-bit command,
// UART TX returns a response byte.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [3:0]    LAST_BIT  = 4'd9;

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_RECV = 1'b1;
    localparam logic [0:0] WAIT_HI = 1'b0;
    localparam logic [0:0] WAIT_LO = 1'b1;
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_XMIT = 1'b1;

    logic          rx_m, rx_s, rx_d;
    logic [0:0]    rx_state;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_byte;
    logic [0:0]    byte_st;
    logic [7:0]    hi_byte;
    logic [0:0]    tx_state;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bits;
    logic [9:0]    tx_shift;

    logic rx_fall, rx_start, rx_tick, rx_last;
    logic byte_rdy, frame_err, cmd_set, tx_tick;

    assign rx_fall   = rx_d & ~rx_s;
    assign rx_start  = (rx_state == RX_IDLE) && rx_fall;
    // Ticks on the last cycle of a bit period, so the count never wraps.
    assign rx_tick   = (rx_state == RX_RECV) && (rx_baud <= BAUD_ONE);
    assign rx_last   = (rx_bits == LAST_BIT);
    assign byte_rdy  = rx_tick && rx_last && rx_s;
    assign frame_err = rx_tick && rx_last && !rx_s;
    assign cmd_set   = byte_rdy && (byte_st == WAIT_LO);
    assign tx_tick   = (tx_state == TX_XMIT) && (tx_baud <= BAUD_ONE);
    assign TX        = tx_shift[0];

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rx_d, rx_s, rx_m} <= 3'b111;
        end else begin
            {rx_d, rx_s, rx_m} <= {rx_s, rx_m, RX};
        end
    end

    // RX bit engine: mid-bit sampling of start, 8 data bits, stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_byte  <= '0;
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_RECV;
                        rx_baud  <= BAUD_HALF;
                        rx_bits  <= '0;
                    end
                end
                RX_RECV: begin
                    if (rx_tick) begin
                        rx_baud <= BAUD_FULL;
                        rx_bits <= rx_bits + 4'd1;
                        if (rx_bits == 4'd0 && rx_s) begin
                            rx_state <= RX_IDLE;
                        end else if (rx_last) begin
                            rx_state <= RX_IDLE;
                        end else if (rx_bits != 4'd0) begin
                            rx_byte <= {rx_s, rx_byte[7:1]};
                        end
                    end else begin
                        rx_baud <= rx_baud - BAUD_ONE;
                    end
                end
            endcase
        end
    end

    // Byte FSM: pairs bytes into cmd and runs the cmd_rdy handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_st <= WAIT_HI;
            hi_byte <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (frame_err) begin
                byte_st <= WAIT_HI;
            end else if (byte_rdy) begin
                unique case (byte_st)
                    WAIT_HI: begin
                        hi_byte <= rx_byte;
                        byte_st <= WAIT_LO;
                    end
                    WAIT_LO: begin
                        cmd     <= {hi_byte, rx_byte};
                        byte_st <= WAIT_HI;
                    end
                endcase
            end
            if (cmd_set) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy
                         || (rx_start && byte_st == WAIT_HI)) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // TX engine: shifts {stop, resp, start} out LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
            tx_done  <= 1'b0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_state <= TX_XMIT;
                        tx_shift <= {1'b1, resp, 1'b0};
                        tx_baud  <= BAUD_FULL;
                        tx_bits  <= '0;
                        tx_done  <= 1'b0;
                    end
                end
                TX_XMIT: begin
                    if (tx_tick) begin
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_baud  <= BAUD_FULL;
                        tx_bits  <= tx_bits + 4'd1;
                        if (tx_bits == LAST_BIT) begin
                            tx_state <= TX_IDLE;
                            tx_done  <= 1'b1;
                        end
                    end else begin
                        tx_baud <= tx_baud - BAUD_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: command receive, response
// transmit, overwrite, framing error, glitch and async reset.
module tb_uart_cmd_wrapper;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    logic [9:0] tx_exp;
    logic [7:0] tx_got;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .trmt        (trmt),
        .resp        (resp),
        .tx_done     (tx_done)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (B) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_cmd(input logic [15:0] c);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        trmt = 1'b0;
        resp = 8'h00;
        tx_got = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", 16'(TX), 16'd1);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
        chk("rst_tx_done", 16'(tx_done), 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: receive 2FF1, then clear handshake
        send_cmd(16'h2FF1);
        chk("t1_cmd", cmd, 16'h2FF1);
        chk("t1_rdy", 16'(cmd_rdy), 16'd1);
        pulse_clr();
        chk("t1_clr", 16'(cmd_rdy), 16'd0);
        chk("t1_cmd_hold", cmd, 16'h2FF1);

        // 2: transmit A5, stray trmt mid-frame and at the end
        tx_exp = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t2_bit%0d", i), 16'(TX), 16'(tx_exp[i]));
            if (i > 0 && i < 9) tx_got[i-1] = TX;
            if (i == 9) chk("t2_done_lo", 16'(tx_done), 16'd0);
            if (i == 3) begin
                trmt = 1'b1;
                resp = 8'h00;
                @(negedge clk);
                trmt = 1'b0;
                repeat (B - 1) @(negedge clk);
            end else if (i < 9) begin
                repeat (B) @(negedge clk);
            end
        end
        chk("t2_byte", 16'(tx_got), 16'h00A5);
        repeat (B / 2 - 1) @(negedge clk);
        resp = 8'h3C;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        chk("t2_done_hi", 16'(tx_done), 16'd1);
        chk("t2_tx_idle", 16'(TX), 16'd1);
        repeat (4) @(negedge clk);
        chk("t2_no_new", 16'(TX), 16'd1);
        chk("t2_done_keep", 16'(tx_done), 16'd1);

        // 3: back-to-back commands without clearing
        send_cmd(16'h4001);
        chk("t3_cmd1", cmd, 16'h4001);
        chk("t3_rdy1", 16'(cmd_rdy), 16'd1);
        RX = 1'b0;
        repeat (B / 2) @(negedge clk);
        chk("t3_rdy_drop", 16'(cmd_rdy), 16'd0);
        chk("t3_cmd_keep", cmd, 16'h4001);
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h40 >> i));
        send_bit(1'b1);
        chk("t3_cmd_mid", cmd, 16'h4001);
        send_byte(8'h12, 1'b1);
        repeat (2) @(negedge clk);
        chk("t3_cmd2", cmd, 16'h4012);
        chk("t3_rdy2", 16'(cmd_rdy), 16'd1);

        // 4: framing error on low byte, then recovery
        send_byte(8'h55, 1'b1);
        send_byte(8'h77, 1'b0);
        RX = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_cmd", cmd, 16'h4012);
        chk("t4_rdy", 16'(cmd_rdy), 16'd0);
        send_cmd(16'h6000);
        chk("t4_cmd_ok", cmd, 16'h6000);
        chk("t4_rdy_ok", 16'(cmd_rdy), 16'd1);

        // 5: one-cycle glitch produces no byte
        pulse_clr();
        RX = 1'b0;
        @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("t5_cmd", cmd, 16'h6000);
        chk("t5_rdy", 16'(cmd_rdy), 16'd0);
        chk("t5_tx", 16'(TX), 16'd1);
        send_cmd(16'h1234);
        chk("t5_cmd_ok", cmd, 16'h1234);
        chk("t5_rdy_ok", 16'(cmd_rdy), 16'd1);

        // 6: async reset mid low byte and mid transmit
        send_byte(8'hAB, 1'b1);
        resp = 8'h00;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t6_pre_tx", 16'(TX), 16'd0);
        chk("t6_pre_done", 16'(tx_done), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_tx", 16'(TX), 16'd1);
        chk("t6_cmd", cmd, 16'h0000);
        chk("t6_rdy", 16'(cmd_rdy), 16'd0);
        chk("t6_done", 16'(tx_done), 16'd0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_tx_idle", 16'(TX), 16'd1);
        send_cmd(16'h9876);
        chk("t6_cmd_new", cmd, 16'h9876);
        chk("t6_rdy_new", 16'(cmd_rdy), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
